// File: rtl/nv_ram_rwsp_prm_pkg.sv
// Shared types and helpers for the parametrised 1R1W staging RAM.
// NV_RAM_PARITY_EN adds one even-parity bit per stored word.
package nv_ram_pkg;

  function automatic int nv_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

`ifdef NV_RAM_PARITY_EN
  localparam int NV_RAM_PAR_W = 1;
`else
  localparam int NV_RAM_PAR_W = 0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } nv_ram_rd_st_t;

endpackage

// File: rtl/nv_ram_rwsp_prm_array.sv
// Bare storage: combinational read, synchronous write, no reset, so FPGA
// flows can map it onto block RAM. Caller guarantees wa_i is in range on writes.
module nv_ram_rwsp_prm_array #(
  parameter int DEPTH = 8,
  parameter int W     = 129,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [W-1:0]  wd_i,
  input  logic [AW-1:0] ra_i,
  output logic [W-1:0]  rd_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wa_i] <= wd_i;
  end

  assign rd_o = mem_q[ra_i];

endmodule

// File: rtl/nv_ram_rwsp_prm.sv
// Parametrised 1R1W RAM with two-stage read, write forwarding and per-entry
// written tracking. Optional even parity under NV_RAM_PARITY_EN.
module nv_ram_rwsp_prm
  import nv_ram_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 129,
  parameter int AW    = nv_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             dout_unwr,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic [31:0]      pwrbus_ram_pd,
  output logic             parity_err
);

  localparam int            MW      = WIDTH + NV_RAM_PAR_W;
  localparam logic [AW:0]   DEPTH_A = (AW + 1)'(DEPTH);

  function automatic logic [MW-1:0] pack_word(input logic [WIDTH-1:0] d);
`ifdef NV_RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [AW-1:0]    ra_q, ra_d;
  nv_ram_rd_st_t    rd_st_q, rd_st_d;
  logic [DEPTH-1:0] wr_vld_q, wr_vld_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             dout_unwr_q, dout_unwr_d;
  logic             par_err_q, par_err_d;

  logic             wa_ok, ra_ok, wr_en, fwd_hit, fwd_vld, par_chk;
  logic [MW-1:0]    arr_wd, arr_rd, fwd_word;
  logic             unused_pwr;

  assign unused_pwr = ^pwrbus_ram_pd;

  assign wa_ok  = {1'b0, wa} < DEPTH_A;
  assign ra_ok  = {1'b0, ra_q} < DEPTH_A;
  assign wr_en  = we && wa_ok && !rst;
  assign arr_wd = pack_word(di);

  nv_ram_rwsp_prm_array #(
    .DEPTH (DEPTH),
    .W     (MW),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we_i  (wr_en),
    .wa_i  (wa),
    .wd_i  (arr_wd),
    .ra_i  (ra_q),
    .rd_o  (arr_rd)
  );

  // Out-of-range read addresses read as unwritten zero, even if wa matches.
  assign fwd_hit  = we && (wa == ra_q) && ra_ok;
  assign fwd_vld  = fwd_hit || (ra_ok && wr_vld_q[ra_q]);
  assign fwd_word = fwd_hit ? arr_wd : (ra_ok ? arr_rd : '0);

`ifdef NV_RAM_PARITY_EN
  assign par_chk = fwd_vld && (fwd_word[WIDTH] != ^fwd_word[WIDTH-1:0]);
`else
  assign par_chk = 1'b0;
`endif

  always_comb begin
    ra_d        = ra_q;
    rd_st_d     = rd_st_q;
    wr_vld_d    = wr_vld_q;
    dout_d      = dout_q;
    dout_unwr_d = dout_unwr_q;
    par_err_d   = par_err_q;
    dout_vld_d  = ore && (rd_st_q == PEND);

    // Stage 1: address capture; a new re keeps a read pending across ore.
    if (re) begin
      ra_d    = ra;
      rd_st_d = PEND;
    end else if (ore) begin
      rd_st_d = IDLE;
    end

    if (we && wa_ok) wr_vld_d[wa] = 1'b1;

    // Stage 2: output register, loaded from the old address.
    if (ore) begin
      dout_d      = fwd_word[WIDTH-1:0];
      dout_unwr_d = !fwd_vld;
      par_err_d   = par_chk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q        <= '0;
      rd_st_q     <= IDLE;
      wr_vld_q    <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_unwr_q <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      ra_q        <= ra_d;
      rd_st_q     <= rd_st_d;
      wr_vld_q    <= wr_vld_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      dout_unwr_q <= dout_unwr_d;
      par_err_q   <= par_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign dout_unwr  = dout_unwr_q;
  assign parity_err = par_err_q;

endmodule
